smc_header_feeder: RTL and testbench

SMC_HEADER_FEEDER -- requirements
Module: smc_header_feeder

---
 rtl/smc_header_feeder.sv | 178 +++++++++++++++++
 tb/tb_smc_header_feeder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/smc_header_feeder.sv
// Locates the SNES cartridge header (LoROM or HiROM, optionally behind a 512-byte
// copier header) by checksum/complement probe, then streams its 64 bytes downstream.
module smc_header_feeder #(
    parameter int                ADDR_W  = 24,
    parameter logic [ADDR_W-1:0] LO_BASE = ADDR_W'(24'h007FC0),
    parameter logic [ADDR_W-1:0] HI_BASE = ADDR_W'(24'h00FFC0)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              copier,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [7:0]        mem_q,
    output logic [7:0]        rom_d,
    output logic              rom_strb,
    output logic              busy,
    output logic              done,
    output logic              hirom,
    output logic              hdr_valid
);

    typedef enum logic [2:0] {IDLE, PROBE, DECIDE, FEED, DONE} state_t;

    localparam logic [ADDR_W-1:0] COPIER_OFF = ADDR_W'(24'h000200);
    localparam logic [ADDR_W-1:0] CSUM_OFF   = ADDR_W'(24'h00001C);

    state_t            state_q, state_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] off_q, off_d;
    logic [2:0]        idx_q, idx_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              fin_q, fin_d;
    logic [7:0]        rom_d_q, rom_d_d;
    logic              strb_q, strb_d;
    logic              hirom_q, hirom_d;
    logic              hv_q, hv_d;
    logic              probe_we;
    logic [7:0]        probe_q [8];

    logic              ack_ok;
    logic              lo_ok, hi_ok;
    logic [ADDR_W-1:0] probe_addr, feed_addr;

    // Only an ack that answers our own outstanding request counts.
    assign ack_ok = rd_q && mem_ack;

    // Candidate is valid when the complement word XOR the checksum word is all ones.
    assign lo_ok = (({probe_q[1], probe_q[0]} ^ {probe_q[3], probe_q[2]}) == 16'hFFFF);
    assign hi_ok = (({probe_q[5], probe_q[4]} ^ {probe_q[7], probe_q[6]}) == 16'hFFFF);

    assign probe_addr = (idx_q[2] ? HI_BASE : LO_BASE) + off_q + CSUM_OFF
                        + ADDR_W'(idx_q[1:0]);
    assign feed_addr  = (hirom_q ? HI_BASE : LO_BASE) + off_q + ADDR_W'(cnt_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            off_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            rom_d_q <= '0;
            strb_q  <= 1'b0;
            hirom_q <= 1'b0;
            hv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            rom_d_q <= rom_d_d;
            strb_q  <= strb_d;
            hirom_q <= hirom_d;
            hv_q    <= hv_d;
        end
    end

    always_ff @(posedge clk) begin
        if (probe_we) begin
            probe_q[idx_q] <= mem_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        off_d    = off_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        fin_d    = fin_q;
        rom_d_d  = rom_d_q;
        strb_d   = 1'b0;
        hirom_d  = hirom_q;
        hv_d     = hv_q;
        probe_we = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = PROBE;
                    off_d   = copier ? COPIER_OFF : '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    fin_d   = 1'b0;
                    hirom_d = 1'b0;
                    hv_d    = 1'b0;
                end
            end
            PROBE: begin
                if (ack_ok) begin
                    rd_d     = 1'b0;
                    probe_we = 1'b1;
                    if (idx_q == 3'd7) begin
                        state_d = DECIDE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else if (!rd_q) begin
                    rd_d   = 1'b1;
                    addr_d = probe_addr;
                end
            end
            DECIDE: begin
                state_d = FEED;
                cnt_d   = '0;
                if (lo_ok) begin
                    hirom_d = 1'b0;
                    hv_d    = 1'b1;
                end else if (hi_ok) begin
                    hirom_d = 1'b1;
                    hv_d    = 1'b1;
                end else begin
                    hirom_d = 1'b0;
                    hv_d    = 1'b0;
                end
            end
            FEED: begin
                if (ack_ok) begin
                    rd_d    = 1'b0;
                    rom_d_d = mem_q;
                    strb_d  = 1'b1;
                    // Latch termination instead of letting the 6-bit counter wrap.
                    if (cnt_q == 6'd63) begin
                        fin_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end else if (!rd_q) begin
                    if (fin_q) begin
                        state_d = DONE;
                    end else begin
                        rd_d   = 1'b1;
                        addr_d = feed_addr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_rd    = rd_q;
    assign mem_addr  = addr_q;
    assign rom_d     = rom_d_q;
    assign rom_strb  = strb_q;
    assign busy      = (state_q == PROBE) || (state_q == DECIDE) || (state_q == FEED);
    assign done      = (state_q == DONE);
    assign hirom     = hirom_q;
    assign hdr_valid = hv_q;

endmodule

// File: tb/tb_smc_header_feeder.sv
// Directed bench for smc_header_feeder: a memory responder checks every read address
// against an expected queue, and a strobe monitor checks streamed bytes against a scoreboard.
module tb_smc_header_feeder;

    logic        clk = 1'b0;
    logic        resetn, start, copier;
    logic [23:0] mem_addr;
    logic        mem_rd, mem_ack;
    logic [7:0]  mem_q, rom_d;
    logic        rom_strb, busy, done, hirom, hdr_valid;

    smc_header_feeder dut (
        .clk(clk), .resetn(resetn), .start(start), .copier(copier),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_q(mem_q),
        .rom_d(rom_d), .rom_strb(rom_strb), .busy(busy), .done(done),
        .hirom(hirom), .hdr_valid(hdr_valid)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          strb_cnt = 0;
    logic        rand_lat = 1'b0;
    logic        stray_en = 1'b0;
    logic [23:0] exp_addr [$];
    logic [7:0]  exp_data [$];
    logic [7:0]  ovr [logic [23:0]];

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s got=event exp=none", name);
    endfunction

    // Background ROM contents, with per-test header overrides on top.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (ovr.exists(a)) return ovr[a];
        return 8'(a[7:0] + 8'(a[15:8] * 8'd3) + 8'(a[23:16] * 8'd7));
    endfunction

    // Memory responder: latency, stability, one-outstanding and address checks.
    initial begin : responder
        logic        pending, ack_prev;
        logic [23:0] req_addr;
        int          wait_left;
        pending = 1'b0; ack_prev = 1'b0; req_addr = '0; wait_left = 0;
        mem_ack = 1'b0; mem_q = 8'h00;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (!resetn) begin
                pending  = 1'b0;
                ack_prev = 1'b0;
            end else begin
                if (ack_prev) chk("rd_low_after_ack", 32'(mem_rd), 32'd0);
                if (pending) begin
                    chk("addr_stable", 32'(mem_addr), 32'(req_addr));
                    chk("rd_held", 32'(mem_rd), 32'd1);
                end else if (mem_rd && !ack_prev) begin
                    pending   = 1'b1;
                    req_addr  = mem_addr;
                    wait_left = rand_lat ? int'($urandom_range(1, 20)) : 1;
                    if (exp_addr.size() == 0) fail_now("unexpected_read");
                    else chk("read_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
                end
                ack_prev = 1'b0;
                if (pending) begin
                    wait_left--;
                    if (wait_left == 0) begin
                        mem_ack  = 1'b1;
                        mem_q    = mem_byte(req_addr);
                        pending  = 1'b0;
                        ack_prev = 1'b1;
                    end
                end else if (stray_en && !mem_rd && $urandom_range(0, 3) == 0) begin
                    mem_ack = 1'b1;
                    mem_q   = 8'hA5;
                end
            end
        end
    end

    // Strobe monitor: pops the byte scoreboard, checks hold and done timing.
    initial begin : monitor
        logic       last_seen;
        logic [7:0] last_d;
        last_seen = 1'b0; last_d = 8'h00;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                last_d    = 8'h00;
                last_seen = 1'b0;
            end else begin
                if (last_seen) begin
                    chk("done_after_64th", 32'(done), 32'd1);
                    last_seen = 1'b0;
                end
                if (rom_strb) begin
                    strb_cnt++;
                    if (exp_data.size() == 0) fail_now("unexpected_strobe");
                    else chk("rom_d", 32'(rom_d), 32'(exp_data.pop_front()));
                    last_d = rom_d;
                    if (strb_cnt == 64) last_seen = 1'b1;
                end else begin
                    chk("rom_d_hold", 32'(rom_d), 32'(last_d));
                end
            end
        end
    end

    task automatic set_lo_image();
        ovr.delete();
        ovr[24'h007FDC] = 8'h34; ovr[24'h007FDD] = 8'h12;
        ovr[24'h007FDE] = 8'hCB; ovr[24'h007FDF] = 8'hED;
    endtask

    task automatic set_hi_image();
        ovr.delete();
        ovr[24'h00FFDC] = 8'h00; ovr[24'h00FFDD] = 8'hFF;
        ovr[24'h00FFDE] = 8'hFF; ovr[24'h00FFDF] = 8'h00;
        for (int i = 0; i < 4; i++) ovr[24'h007FDC + 24'(i)] = 8'h00;
    endtask

    task automatic check_reset_outputs();
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_rom_d", 32'(rom_d), 32'd0);
        chk("rst_rom_strb", 32'(rom_strb), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hirom", 32'(hirom), 32'd0);
        chk("rst_hdr_valid", 32'(hdr_valid), 32'd0);
    endtask

    task automatic begin_run(input logic cop, input logic exp_hi);
        logic [23:0] off, base;
        off  = cop ? 24'h000200 : 24'h000000;
        base = exp_hi ? 24'h00FFC0 : 24'h007FC0;
        for (int i = 0; i < 4; i++) exp_addr.push_back(24'h007FDC + off + 24'(i));
        for (int i = 0; i < 4; i++) exp_addr.push_back(24'h00FFDC + off + 24'(i));
        for (int i = 0; i < 64; i++) begin
            exp_addr.push_back(base + off + 24'(i));
            exp_data.push_back(mem_byte(base + off + 24'(i)));
        end
        strb_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; copier = cop;
        @(posedge clk); #1;
        start = 1'b0; copier = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_cleared", 32'(done), 32'd0);
    endtask

    task automatic finish_run(input logic exp_hi, input logic exp_v);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_reached", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("hirom", 32'(hirom), 32'(exp_hi));
        chk("hdr_valid", 32'(hdr_valid), 32'(exp_v));
        repeat (3) @(posedge clk);
        #1;
        chk("strobe_count", 32'(strb_cnt), 32'd64);
        chk("reads_left", 32'(exp_addr.size()), 32'd0);
        chk("bytes_left", 32'(exp_data.size()), 32'd0);
        $display("run done: hirom=%0d hdr_valid=%0d strobes=%0d", hirom, hdr_valid, strb_cnt);
    endtask

    task automatic wait_strobes(input int target);
        int n;
        n = 0;
        while (strb_cnt < target && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("strobe_wait", 32'(strb_cnt >= target), 32'd1);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; copier = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        check_reset_outputs();

        // LoROM image, single-cycle acks
        set_lo_image();
        begin_run(1'b0, 1'b0);
        finish_run(1'b0, 1'b1);

        // HiROM-only image
        set_hi_image();
        begin_run(1'b0, 1'b1);
        finish_run(1'b1, 1'b1);

        // Copier header, no valid candidate: falls back to LoROM layout
        ovr.delete();
        begin_run(1'b1, 1'b0);
        finish_run(1'b0, 1'b0);

        // Random latency with stray acks
        rand_lat = 1'b1; stray_en = 1'b1;
        set_lo_image();
        begin_run(1'b0, 1'b0);
        finish_run(1'b0, 1'b1);

        // Reset after the 10th strobe, then a clean restart
        set_hi_image();
        begin_run(1'b0, 1'b1);
        wait_strobes(10);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        check_reset_outputs();
        begin_run(1'b0, 1'b1);
        finish_run(1'b1, 1'b1);

        // Start during FEED is ignored
        rand_lat = 1'b0;
        set_lo_image();
        begin_run(1'b0, 1'b0);
        wait_strobes(20);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish_run(1'b0, 1'b1);

        // Restart from DONE re-emits the whole stream
        begin_run(1'b0, 1'b0);
        finish_run(1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
